alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
Shares one combinational 8-bit ALU (4-bit opcode, A/B operands, 8-bit Out plus Carry) between NUM_REQ requesters. Requests are granted round-robin and the operands are latched and presented to the ALU. The result is captured and returned on a single tagged response channel with a valid/ready handshake. Div/Mod with B==0 are trapped and flagged rather than executed. The block sits between the requester clients and the ALU instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index (clog2(NUM_REQ))
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot accept pulse to granted requester
req_opcode  in  4*NUM_REQ  packed opcodes, requester i at [4i+3:4i]
req_a  in  8*NUM_REQ  packed operand A
req_b  in  8*NUM_REQ  packed operand B
alu_opcode  out  4  opcode to ALU
alu_a  out  8  operand A to ALU
alu_b  out  8  operand B to ALU
alu_out  in  8  ALU result
alu_carry  in  1  ALU carry
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of requester owning the response
rsp_out  out  8  captured result
rsp_carry  out  1  captured carry
rsp_err  out  1  divide/modulo by zero trapped
busy  out  1  high in EXEC or RESP
op_count  out  CNT_W  completed responses, saturating

Behaviour:
- Opcode map: 0 Add, 1 Sub, 2 Mul, 3 Div, 4 Mod, 5 And, 6 Or, 7 NotA, 8 Xor, 9 BitWise_And, 10 BitWise_Or, 11 BitWise_NotB, 12 Shift_RightA, 13 Shift_LeftB, 14 IncrementA, 15 DecrementB. Opcodes are passed through to the ALU unmodified; the scheduler does no opcode decode except the Div/Mod trap.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from (last_grant+1) mod NUM_REQ.
  - Assert req_ready[g] combinationally in that cycle only.
  - Latch opcode, A, B and g into registers; next state EXEC.
  - If no req_valid is set, stay in IDLE. req_ready is 0 in every state other than IDLE.
- EXEC (exactly 1 cycle):
  - alu_* outputs are driven from the latched registers, so they are stable throughout EXEC and RESP.
  - At the end of EXEC, capture alu_out and alu_carry into rsp_out and rsp_carry.
  - If the opcode is 3 or 4 and B==0: force rsp_out=0, rsp_carry=0, rsp_err=1. Otherwise rsp_err=0.
  - Update last_grant=g; next state RESP.
- RESP:
  - rsp_valid=1 with rsp_id/out/carry/err held stable.
  - On rsp_valid&&rsp_ready: increment op_count (saturating at all-ones) and go to IDLE.
  - Backpressure: the block holds in RESP indefinitely while rsp_ready=0.
- Latency:
  - Accept in cycle T, rsp_valid first high in cycle T+2.
  - A new grant can occur at the earliest in the cycle after the response handshake, giving a maximum throughput of 1 operation per 3 cycles.
- Fairness: after granting i, every other requester holding valid is granted before i is granted again.
- Requester contract: a requester holds valid/opcode/operands until it sees req_ready. The scheduler ignores a requester that drops valid before being granted.
- Reset (synchronous, rst high at a rising edge), outputs on the following cycle:
  - State=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first.
  - alu_opcode=0, alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_id=0, rsp_out=0, rsp_carry=0, rsp_err=0.
  - busy=0, op_count=0.
  - req_ready is 0 while rst is high.
- Reset mid-operation: reset in EXEC or RESP aborts the operation. No response is issued and op_count is unchanged from its reset value of 0.
- busy = (state!=IDLE).

Test Plan:
1. Reset, then req0 valid with op 0, A=8'hF0, B=8'h20 -> req_ready[0] pulses in cycle 1. Two cycles later rsp_valid=1, rsp_id=0, rsp_out=8'h10, rsp_carry=1; op_count=1 after the handshake.
2. All four requesters valid with ops 1/2/9/13 and A=8'd9, B=8'd3 -> grants in order 0,1,2,3. Responses are 8'd6, 8'd27, 8'd1, 8'd6 with matching rsp_id. Requester 0 is re-granted only after requester 3.
3. req2 op 3 with A=8'd50, B=0 -> rsp_err=1, rsp_out=0, rsp_carry=0. Then op 4 with A=8'd50, B=8'd7 -> rsp_err=0, rsp_out=8'd1.
4. Hold rsp_ready=0 for 10 cycles in RESP -> rsp fields stable, req_ready stays 0, busy=1. Raising rsp_ready completes exactly one transfer.
5. Assert rst during EXEC -> next cycle state is IDLE, rsp_valid=0, op_count=0. The next grant goes to requester 0.
6. Force op_count to all-ones, then complete one more operation -> op_count stays all-ones.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end that shares one combinational ALU between NUM_REQ
// requesters and returns each result on a tagged valid/ready response channel.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_opcode,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [3:0]           alu_opcode,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  input  logic [7:0]           alu_out,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_out,
  output logic                 rsp_carry,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [7:0]      rsp_out_q, rsp_out_d;
  logic            rsp_carry_q, rsp_carry_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [3:0]      op_arr [NUM_REQ];
  logic [7:0]      a_arr  [NUM_REQ];
  logic [7:0]      b_arr  [NUM_REQ];
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            div_trap;

  // Unpack the per-requester fields so the winner can be selected by index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_opcode[4*i +: 4];
      a_arr[i]  = req_a[8*i +: 8];
      b_arr[i]  = req_b[8*i +: 8];
    end
  end

  // Search upward starting just after the previous winner, wrapping at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign div_trap = ((opcode_q == 4'd3) || (opcode_q == 4'd4)) && (b_q == 8'd0);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    opcode_d     = opcode_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_out_d    = rsp_out_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          id_d                 = grant_idx;
          opcode_d             = op_arr[grant_idx];
          a_d                  = a_arr[grant_idx];
          b_d                  = b_arr[grant_idx];
          state_d              = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d    = div_trap ? 8'd0 : alu_out;
        rsp_carry_d  = div_trap ? 1'b0 : alu_carry;
        rsp_err_d    = div_trap;
        last_grant_d = id_q;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (op_count_q != '1) op_count_d = op_count_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      id_q         <= '0;
      opcode_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_out_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      opcode_q     <= opcode_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_out_q    <= rsp_out_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_opcode = opcode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign rsp_out    = rsp_out_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: directed vector table, corner-case
// sequences and random traffic against a transaction-level reference model.
module tb_alu_rr_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 16;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    int         id;
    logic [7:0] out;
    logic       carry;
    logic       err;
  } rsp_t;

  typedef struct {
    int         id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       carry;
    logic       err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_opcode = '0;
  logic [8*NUM_REQ-1:0] req_a = '0;
  logic [8*NUM_REQ-1:0] req_b = '0;
  logic [3:0]           alu_opcode;
  logic [7:0]           alu_a, alu_b, alu_out;
  logic                 alu_carry;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_out;
  logic                 rsp_carry, rsp_err, busy;
  logic [CNT_W-1:0]     op_count;

  // Small-counter instance used to reach saturation quickly.
  logic [NUM_REQ-1:0]   s_req_valid = 4'b0001;
  logic [NUM_REQ-1:0]   s_req_ready;
  logic [4*NUM_REQ-1:0] s_req_opcode = '0;
  logic [8*NUM_REQ-1:0] s_req_a = '0;
  logic [8*NUM_REQ-1:0] s_req_b = '0;
  logic [3:0]           s_alu_opcode;
  logic [7:0]           s_alu_a, s_alu_b, s_alu_out;
  logic                 s_alu_carry;
  logic                 s_rsp_valid;
  logic                 s_rsp_ready = 1'b1;
  logic [ID_W-1:0]      s_rsp_id;
  logic [7:0]           s_rsp_out;
  logic                 s_rsp_carry, s_rsp_err, s_busy;
  logic [1:0]           s_op_count;

  // Behavioural ALU the scheduler is meant to sit in front of.
  function automatic logic [8:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'd0:  return {1'b0, a} + {1'b0, b};
      4'd1:  return {a < b, a - b};
      4'd2:  return {|p[15:8], p[7:0]};
      4'd3:  return (b == 0) ? 9'h1AA : {1'b0, a / b};
      4'd4:  return (b == 0) ? 9'h1AA : {1'b0, a % b};
      4'd5:  return {8'd0, (a != 0) && (b != 0)};
      4'd6:  return {8'd0, (a != 0) || (b != 0)};
      4'd7:  return {8'd0, a == 0};
      4'd8:  return {1'b0, a ^ b};
      4'd9:  return {1'b0, a & b};
      4'd10: return {1'b0, a | b};
      4'd11: return {1'b0, ~b};
      4'd12: return {a[0], a >> 1};
      4'd13: return {b[7], b << 1};
      4'd14: return {1'b0, a} + 9'd1;
      default: return {b == 0, b - 8'd1};
    endcase
  endfunction

  assign {alu_carry, alu_out}     = alu_f(alu_opcode, alu_a, alu_b);
  assign {s_alu_carry, s_alu_out} = alu_f(s_alu_opcode, s_alu_a, s_alu_b);

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_opcode(s_req_opcode),
    .req_a(s_req_a), .req_b(s_req_b),
    .alu_opcode(s_alu_opcode), .alu_a(s_alu_a), .alu_b(s_alu_b),
    .alu_out(s_alu_out), .alu_carry(s_alu_carry),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
    .rsp_out(s_rsp_out), .rsp_carry(s_rsp_carry), .rsp_err(s_rsp_err),
    .busy(s_busy), .op_count(s_op_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  // Requester queues and reference model (age: -1 idle, 1 executing, 2 responding).
  op_t  rq [NUM_REQ][$];
  int   grant_log[$];
  rsp_t rsp_log[$];
  int   age    = -1;
  int   last_g = NUM_REQ - 1;
  int   mcount = 0;
  op_t  cur;
  int   exp_id;
  logic [7:0] exp_out;
  logic exp_carry, exp_err;

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_opcode[4*i +: 4] = rq[i][0].op;
        req_a[8*i +: 8]      = rq[i][0].a;
        req_b[8*i +: 8]      = rq[i][0].b;
      end else begin
        req_valid[i]        = 1'b0;
        req_opcode[4*i +: 4] = 4'($urandom);
        req_a[8*i +: 8]      = 8'($urandom);
        req_b[8*i +: 8]      = 8'($urandom);
      end
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic cycle(input logic rdy, input logic r);
    int pop_idx;
    int pick;
    logic [NUM_REQ-1:0] exp_ready;
    logic [8:0] r9;
    rsp_t rs;
    pop_idx   = -1;
    pick      = -1;
    exp_ready = '0;
    rst       = r;
    rsp_ready = rdy;
    drive_reqs();
    @(negedge clk);
    if (r) begin
      check("req_ready_in_reset", 32'(req_ready), 32'd0);
      age    = -1;
      last_g = NUM_REQ - 1;
      mcount = 0;
    end else begin
      if (age < 0) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (last_g + k) % NUM_REQ;
          if (pick < 0 && rq[c].size() > 0) pick = c;
        end
      end
      if (pick >= 0) exp_ready[pick] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(age >= 0));
      check("rsp_valid", 32'(rsp_valid), 32'(age == 2));
      check("op_count", 32'(op_count), mcount);
      if (age >= 1) begin
        check("alu_opcode", 32'(alu_opcode), 32'(cur.op));
        check("alu_a", 32'(alu_a), 32'(cur.a));
        check("alu_b", 32'(alu_b), 32'(cur.b));
      end
      if (age == 2) begin
        check("rsp_id", 32'(rsp_id), exp_id);
        check("rsp_out", 32'(rsp_out), 32'(exp_out));
        check("rsp_carry", 32'(rsp_carry), 32'(exp_carry));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
      if (rsp_valid && rdy) begin
        rs.id = int'(rsp_id); rs.out = rsp_out; rs.carry = rsp_carry; rs.err = rsp_err;
        rsp_log.push_back(rs);
      end
      if (age < 0) begin
        if (pick >= 0) begin
          cur       = rq[pick][0];
          exp_id    = pick;
          last_g    = pick;
          pop_idx   = pick;
          age       = 1;
          r9        = alu_f(cur.op, cur.a, cur.b);
          exp_err   = ((cur.op == 4'd3) || (cur.op == 4'd4)) && (cur.b == 8'd0);
          exp_out   = exp_err ? 8'd0 : r9[7:0];
          exp_carry = exp_err ? 1'b0 : r9[8];
        end
      end else if (age == 2) begin
        if (rdy) begin
          age = -1;
          mcount++;
        end
      end else begin
        age = 2;
      end
    end
    @(posedge clk);
    #1;
    if (pop_idx >= 0) void'(rq[pop_idx].pop_front());
  endtask

  task automatic reset_check();
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_out", 32'(rsp_out), 32'd0);
    check("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
  endtask

  function automatic op_t mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    op_t o;
    o.op = op; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic bit model_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) return 1'b0;
    return age < 0;
  endfunction

  task automatic run_until_rsp(input int target, input int budget, input logic rdy);
    for (int t = 0; t < budget && rsp_log.size() < target; t++) cycle(rdy, 1'b0);
    check("rsp_count_reached", rsp_log.size(), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   g0, r0;
    int   exp_g[5];
    logic [7:0] exp_o[5];

    vecs[0] = '{0, 4'd0,  8'hF0,  8'h20, 8'h10,  1'b1, 1'b0};
    vecs[1] = '{2, 4'd3,  8'd50,  8'd0,  8'd0,   1'b0, 1'b1};
    vecs[2] = '{2, 4'd4,  8'd50,  8'd7,  8'd1,   1'b0, 1'b0};
    vecs[3] = '{1, 4'd14, 8'hFF,  8'h00, 8'h00,  1'b1, 1'b0};
    vecs[4] = '{3, 4'd3,  8'd100, 8'd7,  8'd14,  1'b0, 1'b0};

    @(posedge clk); #1;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    reset_check();

    // Directed vectors: single requests, including the divide/modulo trap.
    foreach (vecs[v]) begin
      r0 = rsp_log.size();
      rq[vecs[v].id].push_back(mk(vecs[v].op, vecs[v].a, vecs[v].b));
      run_until_rsp(r0 + 1, 20, 1'b1);
      if (rsp_log.size() == r0 + 1) begin
        check("vec_id", rsp_log[r0].id, vecs[v].id);
        check("vec_out", 32'(rsp_log[r0].out), 32'(vecs[v].out));
        check("vec_carry", 32'(rsp_log[r0].carry), 32'(vecs[v].carry));
        check("vec_err", 32'(rsp_log[r0].err), 32'(vecs[v].err));
      end
      if (v == 0) check("op_count_after_first", 32'(op_count), 32'd1);
    end

    // All four requesters at once; requester 0 queues a second op.
    g0 = grant_log.size();
    r0 = rsp_log.size();
    rq[0].push_back(mk(4'd1, 8'd9, 8'd3));
    rq[0].push_back(mk(4'd0, 8'd9, 8'd3));
    rq[1].push_back(mk(4'd2, 8'd9, 8'd3));
    rq[2].push_back(mk(4'd9, 8'd9, 8'd3));
    rq[3].push_back(mk(4'd13, 8'd9, 8'd3));
    run_until_rsp(r0 + 5, 40, 1'b1);
    exp_g = '{0, 1, 2, 3, 0};
    exp_o = '{8'd6, 8'd27, 8'd1, 8'd6, 8'd12};
    if (grant_log.size() >= g0 + 5 && rsp_log.size() >= r0 + 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_grant_order", grant_log[g0 + i], exp_g[i]);
        check("rr_rsp_id", rsp_log[r0 + i].id, exp_g[i]);
        check("rr_rsp_out", 32'(rsp_log[r0 + i].out), 32'(exp_o[i]));
      end
    end

    // Backpressure: hold in RESP while another requester waits.
    r0 = rsp_log.size();
    rq[1].push_back(mk(4'd8, 8'h5A, 8'h0F));
    rq[2].push_back(mk(4'd10, 8'h11, 8'h22));
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0);
    check("bp_no_transfer", rsp_log.size(), r0);
    check("bp_busy", 32'(busy), 32'd1);
    cycle(1'b1, 1'b0);
    check("bp_one_transfer", rsp_log.size(), r0 + 1);
    if (rsp_log.size() == r0 + 1) begin
      check("bp_rsp_id", rsp_log[r0].id, 1);
      check("bp_rsp_out", 32'(rsp_log[r0].out), 32'h55);
    end
    run_until_rsp(r0 + 2, 20, 1'b1);

    // Reset while executing: operation discarded, arbitration restarts at 0.
    rq[3].push_back(mk(4'd0, 8'd1, 8'd2));
    cycle(1'b1, 1'b0);
    check("exec_busy_before_rst", 32'(busy), 32'd1);
    cycle(1'b1, 1'b1);
    reset_check();
    g0 = grant_log.size();
    r0 = rsp_log.size();
    rq[3].push_back(mk(4'd0, 8'd3, 8'd4));
    rq[0].push_back(mk(4'd0, 8'd5, 8'd6));
    run_until_rsp(r0 + 2, 20, 1'b1);
    if (grant_log.size() >= g0 + 2) begin
      check("post_rst_first_grant", grant_log[g0], 0);
      check("post_rst_second_grant", grant_log[g0 + 1], 3);
    end

    // Random traffic against the reference model.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        int r;
        logic [7:0] b;
        r = $urandom_range(0, NUM_REQ - 1);
        b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        if (rq[r].size() < 3) rq[r].push_back(mk(4'($urandom_range(0, 15)), 8'($urandom), b));
      end
      cycle(1'($urandom_range(0, 3) != 0), 1'b0);
    end
    for (int t = 0; t < 100 && !model_empty(); t++) cycle(1'b1, 1'b0);
    check("random_drained", 32'(model_empty()), 32'd1);

    // Saturation on the 2-bit counter instance (ops run every 3 cycles).
    for (int t = 0; t < 30; t++) cycle(1'b1, 1'b0);
    check("sat_reached", 32'(s_op_count), 32'd3);
    for (int t = 0; t < 7; t++) cycle(1'b1, 1'b0);
    check("sat_held", 32'(s_op_count), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
